// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: FSM states,
// requester codes, access-length codes and the default IO region base.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRd   = 2'b01,
        StWr   = 2'b10,
        StDone = 2'b11
    } state_e;

    typedef enum logic {
        OwnIf  = 1'b0,
        OwnMem = 1'b1
    } owner_e;

    localparam logic [1:0] LenByte = 2'b00;
    localparam logic [1:0] LenHalf = 2'b01;
    localparam logic [1:0] LenWord = 2'b11;

    localparam logic [31:0] DefIoBase = 32'h0003_0000;

    // Byte count for a length code; the illegal code 2'b10 behaves as a word.
    function automatic logic [2:0] len_to_count(input logic [1:0] len);
        logic [2:0] cnt;
        case (len)
            LenByte: cnt = 3'd1;
            LenHalf: cnt = 3'd2;
            LenWord: cnt = 3'd4;
            default: cnt = 3'd4;
        endcase
        return cnt;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates IF and MEM onto the byte-wide RAM port and serialises 1/2/4-byte
// accesses. Optional macro MEMCTRL_IO_FULL_EN adds IO write back-pressure.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
`ifdef MEMCTRL_IO_FULL_EN
    ,
    parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(DefIoBase)
`endif
) (
    input  logic              clk_i,
    input  logic              rst_i,
`ifdef MEMCTRL_IO_FULL_EN
    input  logic              io_buffer_full_i,
`endif
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_flush_i,
    output logic              if_done_o,
    output logic [31:0]       if_rdata_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [1:0]        mem_len_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic              mem_done_o,
    output logic [31:0]       mem_rdata_o,
    input  logic [7:0]        ram_din_i,
    output logic [7:0]        ram_dout_o,
    output logic [ADDR_W-1:0] ram_a_o,
    output logic              ram_wr_o
);

    state_e              state_q,     state_d;
    owner_e              owner_q,     owner_d;
    logic [ADDR_W-1:0]   base_q,      base_d;
    logic [2:0]          n_q,         n_d;
    logic [2:0]          i_q,         i_d;
    logic [2:0]          r_q,         r_d;
    logic [31:0]         wdata_q,     wdata_d;
    logic [ADDR_W-1:0]   ram_a_q,     ram_a_d;
    logic                ram_wr_q,    ram_wr_d;
    logic [7:0]          ram_dout_q,  ram_dout_d;
    logic                if_done_q,   if_done_d;
    logic                mem_done_q,  mem_done_d;
    logic [31:0]         if_rdata_q,  if_rdata_d;
    logic [31:0]         mem_rdata_q, mem_rdata_d;

    logic [2:0]          i_nxt_s;
    logic                wr_stall_s;

    assign i_nxt_s = i_q + 3'd1;

`ifdef MEMCTRL_IO_FULL_EN
    // Hold the pending write byte while the IO sink cannot accept it.
    assign wr_stall_s = (state_q == StWr) && io_buffer_full_i && (ram_a_q >= IO_BASE);
`else
    assign wr_stall_s = 1'b0;
`endif

    assign ram_a_o     = ram_a_q;
    assign ram_wr_o    = ram_wr_q & ~wr_stall_s;
    assign ram_dout_o  = ram_dout_q;
    assign if_done_o   = if_done_q;
    assign if_rdata_o  = if_rdata_q;
    assign mem_done_o  = mem_done_q;
    assign mem_rdata_o = mem_rdata_q;

    // Next-state and next-output logic; RAM port values are prepared one cycle ahead.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        base_d      = base_q;
        n_d         = n_q;
        i_d         = i_q;
        r_d         = r_q;
        wdata_d     = wdata_q;
        ram_a_d     = '0;
        ram_wr_d    = 1'b0;
        ram_dout_d  = 8'h00;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;

        case (state_q)
            StIdle: begin
                i_d = 3'd0;
                r_d = 3'd0;
                if (mem_req_i) begin
                    owner_d = OwnMem;
                    base_d  = mem_addr_i;
                    n_d     = len_to_count(mem_len_i);
                    wdata_d = mem_wdata_i;
                    ram_a_d = mem_addr_i;
                    if (mem_we_i) begin
                        state_d    = StWr;
                        ram_wr_d   = 1'b1;
                        ram_dout_d = mem_wdata_i[7:0];
                    end else begin
                        state_d     = StRd;
                        mem_rdata_d = 32'h0000_0000;
                    end
                end else if (if_req_i && !if_flush_i) begin
                    owner_d = OwnIf;
                    base_d  = if_addr_i;
                    n_d     = 3'd4;
                    ram_a_d = if_addr_i;
                    state_d = StRd;
                end else begin
                    state_d = StIdle;
                end
            end

            StRd: begin
                if ((owner_q == OwnIf) && if_flush_i) begin
                    state_d = StIdle;
                    i_d     = 3'd0;
                    r_d     = 3'd0;
                end else begin
                    if (i_q < n_q) begin
                        i_d = i_nxt_s;
                        if (i_nxt_s < n_q) begin
                            ram_a_d = base_q + ADDR_W'(i_nxt_s);
                        end else begin
                            ram_a_d = '0;
                        end
                    end else begin
                        i_d = i_q;
                    end

                    // ram_din answers the address issued in the previous cycle.
                    if (r_q < i_q) begin
                        r_d = r_q + 3'd1;
                        if (owner_q == OwnIf) begin
                            if_rdata_d[{r_q[1:0], 3'b000} +: 8] = ram_din_i;
                        end else begin
                            mem_rdata_d[{r_q[1:0], 3'b000} +: 8] = ram_din_i;
                        end
                        if (r_q == (n_q - 3'd1)) begin
                            state_d    = StDone;
                            if_done_d  = (owner_q == OwnIf);
                            mem_done_d = (owner_q == OwnMem);
                        end else begin
                            state_d = StRd;
                        end
                    end else begin
                        r_d = r_q;
                    end
                end
            end

            StWr: begin
                if (wr_stall_s) begin
                    ram_a_d    = ram_a_q;
                    ram_wr_d   = 1'b1;
                    ram_dout_d = ram_dout_q;
                end else if (i_nxt_s < n_q) begin
                    i_d        = i_nxt_s;
                    ram_a_d    = base_q + ADDR_W'(i_nxt_s);
                    ram_wr_d   = 1'b1;
                    ram_dout_d = wdata_q[{i_nxt_s[1:0], 3'b000} +: 8];
                end else begin
                    state_d    = StDone;
                    i_d        = 3'd0;
                    mem_done_d = 1'b1;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            owner_q     <= OwnIf;
            base_q      <= '0;
            n_q         <= 3'd0;
            i_q         <= 3'd0;
            r_q         <= 3'd0;
            wdata_q     <= 32'h0000_0000;
            ram_a_q     <= '0;
            ram_wr_q    <= 1'b0;
            ram_dout_q  <= 8'h00;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_rdata_q  <= 32'h0000_0000;
            mem_rdata_q <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            base_q      <= base_d;
            n_q         <= n_d;
            i_q         <= i_d;
            r_q         <= r_d;
            wdata_q     <= wdata_d;
            ram_a_q     <= ram_a_d;
            ram_wr_q    <= ram_wr_d;
            ram_dout_q  <= ram_dout_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a transaction-level model queues the expected
// RAM-port and done/rdata values per cycle; one process compares them.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, if_done;
    logic [31:0] if_addr, if_rdata;
    logic        mem_req, mem_we, mem_done;
    logic [1:0]  mem_len;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  ram_din, ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;
`ifdef MEMCTRL_IO_FULL_EN
    logic        io_full;
`endif

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
`ifdef MEMCTRL_IO_FULL_EN
        .io_buffer_full_i (io_full),
`endif
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_flush_i  (if_flush),
        .if_done_o   (if_done),
        .if_rdata_o  (if_rdata),
        .mem_req_i   (mem_req),
        .mem_we_i    (mem_we),
        .mem_len_i   (mem_len),
        .mem_addr_i  (mem_addr),
        .mem_wdata_i (mem_wdata),
        .mem_done_o  (mem_done),
        .mem_rdata_o (mem_rdata),
        .ram_din_i   (ram_din),
        .ram_dout_o  (ram_dout),
        .ram_a_o     (ram_a),
        .ram_wr_o    (ram_wr)
    );

    typedef struct {
        bit          chk_a;
        logic [31:0] a;
        bit          wr;
        bit          chk_dout;
        logic [7:0]  dout;
        bit          ifd;
        bit          memd;
        bit          chk_rd;
        logic [31:0] rd;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [7:0]  ram     [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];

    // Synchronous RAM: read data follows the previous cycle's address.
    always @(posedge clk) begin
        ram_din <= ram.exists(ram_a) ? ram[ram_a] : 8'h00;
        if (ram_wr) ram[ram_a] = ram_dout;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, want);
        end
    endtask

    // Per-cycle comparison against the queued expectations.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("ram_wr", 32'(ram_wr), 32'(e.wr));
            if (e.chk_a) check("ram_a", ram_a, e.a);
            if (e.chk_dout) check("ram_dout", 32'(ram_dout), 32'(e.dout));
            check("if_done", 32'(if_done), 32'(e.ifd));
            check("mem_done", 32'(mem_done), 32'(e.memd));
            if (e.chk_rd && e.ifd) check("if_rdata", if_rdata, e.rd);
            if (e.chk_rd && e.memd) check("mem_rdata", mem_rdata, e.rd);
        end
    end

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
        logic [31:0] w = 32'h0;
        for (int k = 0; k < n; k++) w[8*k +: 8] = ref_byte(a + 32'(k));
        return w;
    endfunction

    function automatic int len_n(input logic [1:0] len);
        case (len)
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic void push_e(input bit chk_a, input logic [31:0] a, input bit wr,
                                   input bit chk_dout, input logic [7:0] dout, input bit ifd,
                                   input bit memd, input bit chk_rd, input logic [31:0] rd);
        exp_t e;
        e.chk_a = chk_a; e.a = a; e.wr = wr; e.chk_dout = chk_dout; e.dout = dout;
        e.ifd = ifd; e.memd = memd; e.chk_rd = chk_rd; e.rd = rd;
        exp_q.push_back(e);
    endfunction

    function automatic void push_idle();
        push_e(1'b1, 32'h0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0);
    endfunction

    // Read: address k in cycle k+1, one capture cycle, then done in cycle N+2.
    function automatic void push_rd(input logic [31:0] a, input int n, input bit is_mem);
        logic [31:0] w = model_read(a, n);
        for (int k = 0; k < n; k++)
            push_e(1'b1, a + 32'(k), 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0);
        push_e(1'b0, 32'h0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0);
        push_e(1'b0, 32'h0, 1'b0, 1'b0, 8'h00, !is_mem, is_mem, 1'b1, w);
    endfunction

    // Write: byte k in cycle k+1, done in cycle N+1.
    function automatic void push_wr(input logic [31:0] a, input int n, input logic [31:0] wd);
        for (int k = 0; k < n; k++) begin
            push_e(1'b1, a + 32'(k), 1'b1, 1'b1, wd[8*k +: 8], 1'b0, 1'b0, 1'b0, 32'h0);
            ref_mem[a + 32'(k)] = wd[8*k +: 8];
        end
        push_e(1'b0, 32'h0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0);
    endfunction

    function automatic void preload(input logic [31:0] a, input logic [7:0] d);
        ram[a] = d;
        ref_mem[a] = d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic if_read(input logic [31:0] a);
        if_req = 1'b1; if_addr = a;
        push_idle();
        push_rd(a, 4, 1'b0);
        tick();
        if_addr = ~a;
        repeat (5) tick();
        if_req = 1'b0;
        tick();
    endtask

    task automatic mem_op(input bit we, input logic [1:0] len, input logic [31:0] a,
                          input logic [31:0] wd);
        int n = len_n(len);
        mem_req = 1'b1; mem_we = we; mem_len = len; mem_addr = a; mem_wdata = wd;
        push_idle();
        if (we) push_wr(a, n, wd);
        else    push_rd(a, n, 1'b1);
        tick();
        mem_addr = ~a; mem_wdata = ~wd; mem_len = ~len; mem_we = ~we;
        repeat (we ? n : n + 1) tick();
        mem_req = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; if_flush = 1'b0;
        mem_req = 1'b0; mem_we = 1'b0; mem_len = 2'b00; mem_addr = 32'h0; mem_wdata = 32'h0;
`ifdef MEMCTRL_IO_FULL_EN
        io_full = 1'b0;
`endif
        preload(32'h1000, 8'h13); preload(32'h1001, 8'h05);
        preload(32'h1002, 8'h00); preload(32'h1003, 8'h00);
        preload(32'h3000, 8'h93); preload(32'h3001, 8'h00);
        preload(32'h3002, 8'h10); preload(32'h3003, 8'h00);
        preload(32'hFFFF_FFFE, 8'h11); preload(32'hFFFF_FFFF, 8'h22);
        preload(32'h0000_0000, 8'h33); preload(32'h0000_0001, 8'h44);

        repeat (2) @(posedge clk);
        #1;
        check("reset ram_a", ram_a, 32'h0);
        check("reset ram_wr", 32'(ram_wr), 32'h0);
        check("reset ram_dout", 32'(ram_dout), 32'h0);
        check("reset if_done", 32'(if_done), 32'h0);
        check("reset mem_done", 32'(mem_done), 32'h0);
        check("reset if_rdata", if_rdata, 32'h0);
        check("reset mem_rdata", mem_rdata, 32'h0);
        rst = 1'b0;
        tick();

        check("model pin 0x1000", model_read(32'h1000, 4), 32'h0000_0513);
        if_read(32'h1000);
        check("if word 0x1000", if_rdata, 32'h0000_0513);

        // MEM and IF request together: store first, IF in the idle cycle after DONE.
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b11; mem_addr = 32'h2000;
        mem_wdata = 32'hDEAD_BEEF; if_req = 1'b1; if_addr = 32'h1000;
        push_idle();
        push_wr(32'h2000, 4, 32'hDEAD_BEEF);
        push_idle();
        push_rd(32'h1000, 4, 1'b0);
        tick();
        repeat (4) tick();
        mem_req = 1'b0;
        tick();
        repeat (6) tick();
        if_req = 1'b0;
        tick();

        mem_op(1'b0, 2'b01, 32'h2002, 32'h0);
        check("load half 0x2002", mem_rdata, 32'h0000_DEAD);
        mem_op(1'b0, 2'b00, 32'h2003, 32'h0);
        check("load byte 0x2003", mem_rdata, 32'h0000_00DE);
        mem_op(1'b0, 2'b10, 32'h2000, 32'h0);
        check("load len10 as word", mem_rdata, 32'hDEAD_BEEF);
        mem_op(1'b1, 2'b01, 32'h2100, 32'hCAFE_1234);
        mem_op(1'b1, 2'b00, 32'h2102, 32'h7777_77A5);
        mem_op(1'b0, 2'b11, 32'h2100, 32'h0);
        check("half+byte stores", mem_rdata, 32'h00A5_1234);

        // Flush together with a fresh IF request blocks the grant.
        if_req = 1'b1; if_addr = 32'h1000; if_flush = 1'b1;
        push_idle();
        tick();
        if_flush = 1'b0;
        if_read(32'h1000);

        // Flush in cycle 3 of an IF read aborts it.
        if_req = 1'b1; if_addr = 32'h1000;
        push_idle();
        for (int k = 0; k < 3; k++)
            push_e(1'b1, 32'h1000 + 32'(k), 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (3) tick();
        if_flush = 1'b1;
        tick();
        if_flush = 1'b0; if_req = 1'b0;
        push_idle();
        tick();
        if_read(32'h3000);
        check("if after flush", if_rdata, 32'h0010_0093);

        if_read(32'hFFFF_FFFE);
        check("wrap read", if_rdata, 32'h4433_2211);

`ifdef MEMCTRL_IO_FULL_EN
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b00; mem_addr = 32'h0003_0004;
        mem_wdata = 32'h0000_00A5; io_full = 1'b1;
        push_idle();
        for (int k = 0; k < 3; k++)
            push_e(1'b1, 32'h0003_0004, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0);
        push_wr(32'h0003_0004, 1, 32'h0000_00A5);
        tick();
        mem_addr = 32'h0;
        repeat (3) tick();
        io_full = 1'b0;
        tick();
        mem_req = 1'b0;
        tick();
        mem_op(1'b0, 2'b00, 32'h0003_0004, 32'h0);
        check("io store readback", mem_rdata, 32'h0000_00A5);
`endif

        // Asynchronous reset in the middle of a word store.
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b11; mem_addr = 32'h2200;
        mem_wdata = 32'h0102_0304;
        push_idle();
        push_e(1'b1, 32'h2200, 1'b1, 1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 32'h0);
        ref_mem[32'h2200] = 8'h04;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        check("async rst ram_wr", 32'(ram_wr), 32'h0);
        check("async rst ram_a", ram_a, 32'h0);
        check("async rst ram_dout", 32'(ram_dout), 32'h0);
        check("async rst mem_done", 32'(mem_done), 32'h0);
        mem_req = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        mem_op(1'b0, 2'b01, 32'h2200, 32'h0);
        check("after rst readback", mem_rdata, 32'h0000_0004);

        check("exp queue drained", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
